// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with KMP failure transitions.
// Mealy or Moore match output, optional overlap, saturating match counter.
module seq_detect_param #(
    parameter int              LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1011,
    parameter int              OVERLAP = 1,
    parameter int              MOORE   = 0,
    parameter int              CNT_W   = 8,
    localparam int             SW      = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic [SW-1:0]    progress,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int TW = 2 * LEN * SW;

    // Serial-order pattern bit: index 0 is the first bit received.
    function automatic logic pat_bit(input int i);
        logic [LEN-1:0] t;
        t = PATTERN >> (LEN - 1 - i);
        return t[0];
    endfunction

    // Longest prefix of PATTERN that ends the string pattern[0..k-1],b.
    function automatic int step_of(input int k, input logic b);
        int   best;
        logic ok;
        logic s;
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                s = (k + 1 - j + i < k) ? pat_bit(k + 1 - j + i) : b;
                if (s != pat_bit(i))
                    ok = 1'b0;
            end
            if (ok)
                best = j;
        end
        return best;
    endfunction

    // State entered after a complete match.
    function automatic int post_of();
        int   best;
        logic ok;
        best = 0;
        if (OVERLAP != 0) begin
            for (int j = 1; j < LEN; j++) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (pat_bit(LEN - j + i) != pat_bit(i))
                        ok = 1'b0;
                end
                if (ok)
                    best = j;
            end
        end
        return best;
    endfunction

    localparam int POST = post_of();

    // Packed next-state table, entry (2*k + din) holds the successor of k.
    function automatic logic [TW-1:0] build_tbl();
        logic [TW-1:0] t;
        int            v;
        t = '0;
        for (int k = 0; k < LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                v = step_of(k, b != 0);
                if (v == LEN && MOORE == 0)
                    v = POST;
                t[(2 * k + b) * SW +: SW] = SW'(v);
            end
        end
        return t;
    endfunction

    localparam logic [TW-1:0] NXT    = build_tbl();
    localparam logic [SW-1:0] S_LAST = SW'(LEN - 1);
    localparam logic [SW-1:0] S_FULL = SW'(LEN);
    localparam logic [SW-1:0] S_POST = SW'(POST);

    logic [SW-1:0]    r_state;
    logic [SW-1:0]    w_next;
    logic [SW-1:0]    w_src;
    logic [TW-1:0]    w_sh;
    logic             w_full;
    logic             w_sat;
    logic [CNT_W-1:0] r_count;

    // State register; reset drops any partial progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= '0;
        else
            r_state <= w_next;
    end

    // Next state via the elaborated table; Moore full state acts as POST.
    always_comb begin
        w_src  = r_state;
        w_next = r_state;
        w_full = 1'b0;
        w_sh   = '0;
        if (MOORE != 0 && r_state == S_FULL)
            w_src = S_POST;
        if (en) begin
            w_full = (w_src == S_LAST) && (din == PATTERN[0]);
            w_sh   = NXT >> (SW * int'({w_src, din}));
            w_next = w_sh[SW-1:0];
        end
    end

    // Saturating match counter; clear wins over a same-edge match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (w_full && !w_sat)
            r_count <= r_count + 1'b1;
    end

    assign w_sat    = &r_count;
    assign sat      = w_sat;
    assign count    = r_count;
    assign progress = r_state;
    assign match    = ~reset & ((MOORE != 0) ? (r_state == S_FULL) : w_full);

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four configurations on shared stimulus,
// checked every cycle against a bit-history model plus literal points.
module tb_seq_detect_param;

    localparam int         N   = 4;
    localparam int         L   = 4;
    localparam logic [3:0] PAT = 4'b1011;
    localparam int OV [N] = '{1, 0, 1, 1};
    localparam int MO [N] = '{0, 0, 1, 0};
    localparam int CW [N] = '{8, 8, 8, 2};

    localparam bit EXP_A [7]  = '{0, 0, 0, 1, 0, 0, 1};
    localparam bit EXP_B [7]  = '{0, 0, 0, 1, 0, 0, 0};
    localparam int EXP_P [5]  = '{1, 2, 0, 1, 1};
    localparam int EXP_D [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;
    logic din   = 1'b0;
    logic clr   = 1'b0;

    logic       m_a, m_b, m_c, m_d;
    logic       s_a, s_b, s_c, s_d;
    logic [2:0] p_a, p_b, p_c, p_d;
    logic [7:0] c_a, c_b, c_c;
    logic [1:0] c_d;

    logic       m  [N];
    logic       st [N];
    logic [2:0] pg [N];
    logic [7:0] ct [N];
    bit         seen [N];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] hb [N];
    int         hl [N];
    bit         mf [N];
    int         mc [N];

    always #5 clk = ~clk;

    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1),
                       .MOORE(0), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr),
        .match(m_a), .progress(p_a), .count(c_a), .sat(s_a));

    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0),
                       .MOORE(0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr),
        .match(m_b), .progress(p_b), .count(c_b), .sat(s_b));

    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1),
                       .MOORE(1), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr),
        .match(m_c), .progress(p_c), .count(c_c), .sat(s_c));

    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1),
                       .MOORE(0), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr),
        .match(m_d), .progress(p_d), .count(c_d), .sat(s_d));

    assign m[0]  = m_a;
    assign m[1]  = m_b;
    assign m[2]  = m_c;
    assign m[3]  = m_d;
    assign st[0] = s_a;
    assign st[1] = s_b;
    assign st[2] = s_c;
    assign st[3] = s_d;
    assign pg[0] = p_a;
    assign pg[1] = p_b;
    assign pg[2] = p_c;
    assign pg[3] = p_d;
    assign ct[0] = c_a;
    assign ct[1] = c_b;
    assign ct[2] = c_c;
    assign ct[3] = {6'b0, c_d};

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // True when the newest j of n history bits equal the first j pattern bits.
    function automatic bit sfx_pfx(input logic [3:0] bits, input int n,
                                   input int j);
        if (j > n)
            return 1'b0;
        for (int i = 0; i < j; i++) begin
            if (bits[j - 1 - i] != PAT[L - 1 - i])
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int mprog(input int i);
        if (MO[i] != 0 && mf[i])
            return L;
        for (int j = L - 1; j > 0; j--) begin
            if (sfx_pfx(hb[i], hl[i], j))
                return j;
        end
        return 0;
    endfunction

    function automatic bit wmatch(input int i, input logic d);
        int n;
        n = (hl[i] < L) ? hl[i] + 1 : L;
        return sfx_pfx({hb[i][2:0], d}, n, L);
    endfunction

    function automatic int cmax(input int i);
        return (1 << CW[i]) - 1;
    endfunction

    // Model: history of accepted bits, Moore full flag, match counter.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                hb[i] <= '0;
                hl[i] <= 0;
                mf[i] <= 1'b0;
                mc[i] <= 0;
            end else begin
                if (en) begin
                    if (wmatch(i, din) && OV[i] == 0) begin
                        hb[i] <= '0;
                        hl[i] <= 0;
                    end else begin
                        hb[i] <= {hb[i][2:0], din};
                        hl[i] <= (hl[i] < L) ? hl[i] + 1 : L;
                    end
                    mf[i] <= wmatch(i, din);
                end
                if (clr)
                    mc[i] <= 0;
                else if (en && wmatch(i, din) && mc[i] < cmax(i))
                    mc[i] <= mc[i] + 1;
            end
        end
    end

    // Every-cycle comparison of all four instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("prog%0d", i), int'(pg[i]), mprog(i));
            chk($sformatf("match%0d", i), int'(m[i]),
                reset ? 0 :
                (MO[i] != 0) ? int'(mf[i]) : int'(en && wmatch(i, din)));
            chk($sformatf("count%0d", i), int'(ct[i]), mc[i]);
            chk($sformatf("sat%0d", i), int'(st[i]),
                int'(mc[i] == cmax(i)));
        end
    end

    task automatic bit_in(input logic d, input logic c);
        @(posedge clk);
        #1;
        en  = 1'b1;
        din = d;
        clr = c;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            seen[i] = m[i];
        @(posedge clk);
        #1;
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [6:0]  s1;
        logic [4:0]  s2;
        logic [3:0]  s3;
        logic [12:0] s4;
        s1 = 7'b1011011;
        s2 = 5'b10011;
        s3 = 4'b1011;
        s4 = 13'b1011011011011;

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_prog", int'(pg[0]), 0);
        chk("rst_count", int'(ct[0]), 0);
        chk("rst_sat", int'(st[0]), 0);
        en  = 1'b1;
        din = 1'b1;
        @(negedge clk);
        chk("rst_en_prog", int'(pg[0]), 0);
        chk("rst_en_match_moore", int'(m[2]), 0);
        en  = 1'b0;
        din = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            bit_in(s1[6 - i], 1'b0);
            chk($sformatf("ovl_match_b%0d", i + 1), int'(seen[0]),
                int'(EXP_A[i]));
            chk($sformatf("novl_match_b%0d", i + 1), int'(seen[1]),
                int'(EXP_B[i]));
            if (i == 3) begin
                chk("ovl_prog_b4", int'(pg[0]), 1);
                chk("novl_prog_b4", int'(pg[1]), 0);
                chk("moore_prog_b4", int'(pg[2]), 4);
                chk("moore_match_b4", int'(m[2]), 1);
            end
        end
        chk("ovl_count", int'(ct[0]), 2);
        chk("novl_count", int'(ct[1]), 1);
        chk("novl_prog_b7", int'(pg[1]), 1);
        chk("moore_count", int'(ct[2]), 2);

        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            bit_in(s2[4 - i], 1'b0);
            chk($sformatf("fail_prog_b%0d", i + 1), int'(pg[0]), EXP_P[i]);
            chk($sformatf("fail_nomatch_b%0d", i + 1), int'(seen[0]), 0);
        end

        pulse_reset();
        for (int i = 0; i < 4; i++)
            bit_in(s3[3 - i], 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk($sformatf("moore_hold_prog%0d", k), int'(pg[2]), 4);
            chk($sformatf("moore_hold_match%0d", k), int'(m[2]), 1);
        end
        chk("moore_hold_count", int'(ct[2]), 1);
        bit_in(1'b0, 1'b0);
        chk("moore_post_prog", int'(pg[2]), 2);
        chk("moore_post_match", int'(m[2]), 0);

        pulse_reset();
        for (int i = 0; i < 13; i++) begin
            bit_in(s4[12 - i], 1'b0);
            chk($sformatf("sat_count_b%0d", i + 1), int'(ct[3]), EXP_D[i]);
        end
        chk("sat_high", int'(st[3]), 1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b1);
        chk("clr_match_kept", int'(seen[3]), 1);
        chk("clr_count", int'(ct[3]), 0);
        chk("clr_sat", int'(st[3]), 0);
        chk("clr_count_wide", int'(ct[0]), 0);

        pulse_reset();
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        chk("mid_prog", int'(pg[0]), 3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_prog", int'(pg[0]), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        bit_in(1'b1, 1'b0);
        chk("after_rst_prog", int'(pg[0]), 1);
        chk("after_rst_match", int'(seen[0]), 0);

        repeat (2) idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000");
        $fatal(1, "watchdog");
    end

endmodule
